// File: rtl/ex_div.sv
// ex_div: EX-stage radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional `DIV_ZERO_TRAP_EN adds div_zero_o, which flags the END cycle of a divide-by-zero.
module ex_div #(
  parameter logic [7:0] DIV_OP  = 8'b00011010,
  parameter logic [7:0] DIVU_OP = 8'b00011011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic        annul,
  output logic        stallreq,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic        div_zero_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t      state;
  logic [31:0] dvd;      // dividend magnitude, consumed MSB-first
  logic [31:0] dvs;      // divisor magnitude
  logic [32:0] rem;      // partial remainder
  logic [31:0] quot;
  logic [5:0]  cnt;
  logic        sign_q;
  logic        sign_r;
`ifdef DIV_ZERO_TRAP_EN
  logic        zero_q;
`endif

  logic        is_div;
  logic        signed_op;
  logic        is_end;
  logic [32:0] shifted;
  logic [32:0] sub;
  logic        ge;

  assign is_div    = (ex_aluop == DIV_OP) || (ex_aluop == DIVU_OP);
  assign signed_op = (ex_aluop == DIV_OP);

  // One restoring step: shift in next dividend bit, trial-subtract the divisor.
  assign shifted = (rem << 1) | {32'b0, dvd[31]};
  assign sub     = shifted - {1'b0, dvs};
  assign ge      = (shifted >= {1'b0, dvs});

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quot   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      zero_q <= 1'b0;
`endif
    end else if (annul) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
`ifdef DIV_ZERO_TRAP_EN
            zero_q <= (ex_reg2 == 32'd0);
`endif
            if (ex_reg2 == 32'd0) begin
              state <= S_DIVZERO;
            end else begin
              dvd    <= (signed_op && ex_reg1[31]) ? -ex_reg1 : ex_reg1;
              dvs    <= (signed_op && ex_reg2[31]) ? -ex_reg2 : ex_reg2;
              sign_q <= signed_op && (ex_reg1[31] ^ ex_reg2[31]);
              sign_r <= signed_op && ex_reg1[31];
              rem    <= '0;
              quot   <= '0;
              cnt    <= '0;
              state  <= S_ON;
            end
          end
        end
        S_DIVZERO: begin
          rem    <= '0;
          quot   <= '0;
          sign_q <= 1'b0;
          sign_r <= 1'b0;
          state  <= S_END;
        end
        S_ON: begin
          rem  <= ge ? sub : shifted;
          quot <= {quot[30:0], ge};
          dvd  <= {dvd[30:0], 1'b0};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_END;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result is only visible in END, and a coincident flush or reset suppresses it.
  assign is_end   = (state == S_END) && !annul && !rst;
  assign stallreq = is_div && (state != S_END) && !annul && !rst;
  assign whilo_o  = is_end;
  assign lo_o     = is_end ? (sign_q ? -quot : quot) : '0;
  assign hi_o     = is_end ? (sign_r ? -rem[31:0] : rem[31:0]) : '0;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero_o = is_end && zero_q;
`endif

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: randomized and directed checks of ex_div against an arithmetic reference model.
module tb_ex_div;
  localparam logic [7:0] DIV_OP  = 8'b00011010;
  localparam logic [7:0] DIVU_OP = 8'b00011011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2;
  logic        annul;
  logic        stallreq, whilo_o;
  logic [31:0] hi_o, lo_o;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses[$];

  ex_div dut (
    .clk(clk), .rst(rst), .ex_aluop(aluop), .ex_reg1(reg1), .ex_reg2(reg2),
    .annul(annul), .stallreq(stallreq), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o)
`ifdef DIV_ZERO_TRAP_EN
    , .div_zero_o(div_zero_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (whilo_o) pulses.push_back(cyc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: C-style truncating division, wraps on overflow, x/0 = 0 r 0.
  task automatic ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a; sb = b;
    if (b == 0) begin q = 0; r = 0; end
    else if (op == DIVU_OP) begin q = a / b; r = a % b; end
    else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin q = 32'h80000000; r = 0; end
    else begin q = sa / sb; r = sa % sb; end
  endtask

  // Presents one op at posedge+1 and checks every cycle up to END (or the kill cycle).
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int kill_at, input bit kill_rst);
    logic [31:0] eq, er;
    int lat, np;
    ref_div(op, a, b, eq, er);
    lat = (b == 0) ? 2 : 33;
    np = pulses.size();
    aluop = op; reg1 = a; reg2 = b;
    for (int c = 0; c <= lat; c++) begin
      if (c == kill_at) begin
        if (kill_rst) rst = 1'b1; else annul = 1'b1;
        @(negedge clk);
        chk("kill_stall", {31'b0, stallreq}, 0);
        chk("kill_whilo", {31'b0, whilo_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0; annul = 1'b0; aluop = 8'h00;
        @(negedge clk);
        chk("after_kill_stall", {31'b0, stallreq}, 0);
        chk("after_kill_hi", hi_o, 0);
        chk("after_kill_lo", lo_o, 0);
        repeat (40) @(posedge clk);
        chk("kill_no_pulse", 32'(pulses.size()), 32'(np));
        #1;
        return;
      end
      @(negedge clk);
      if (c < lat) begin
        chk("stall", {31'b0, stallreq}, 1);
        chk("whilo_early", {31'b0, whilo_o}, 0);
`ifdef DIV_ZERO_TRAP_EN
        chk("dz_early", {31'b0, div_zero_o}, 0);
`endif
      end else begin
        chk("whilo_end", {31'b0, whilo_o}, 1);
        chk("lo", lo_o, eq);
        chk("hi", hi_o, er);
        chk("stall_end", {31'b0, stallreq}, 0);
`ifdef DIV_ZERO_TRAP_EN
        chk("dz_end", {31'b0, div_zero_o}, {31'b0, (b == 0)});
`endif
      end
      @(posedge clk); #1;
    end
    aluop = 8'h00;
  endtask

  initial begin
    int np0;
    logic [7:0] op;
    logic [31:0] a, b;
    rst = 1'b1; annul = 1'b0; aluop = DIV_OP; reg1 = 32'd50; reg2 = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stallreq}, 0);
    chk("rst_whilo", {31'b0, whilo_o}, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    @(posedge clk); #1;
    rst = 1'b0; aluop = 8'h20;
    repeat (3) begin
      @(negedge clk);
      chk("nondiv_stall", {31'b0, stallreq}, 0);
      chk("nondiv_whilo", {31'b0, whilo_o}, 0);
    end
    @(posedge clk); #1;

    do_div(DIVU_OP, 32'd100, 32'd7, -1, 1'b0);
    do_div(DIV_OP, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    do_div(DIV_OP, 32'd7, 32'hFFFFFFFE, -1, 1'b0);
    do_div(DIV_OP, 32'h12345678, 32'd0, -1, 1'b0);
    do_div(DIV_OP, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    do_div(DIVU_OP, 32'd1000, 32'd10, 10, 1'b0);
    do_div(DIVU_OP, 32'd9, 32'd3, -1, 1'b0);
    do_div(DIVU_OP, 32'hDEADBEEF, 32'd13, 20, 1'b1);

    np0 = pulses.size();
    do_div(DIVU_OP, 32'hFFFFFFFF, 32'd1, -1, 1'b0);
    do_div(DIVU_OP, 32'd12345, 32'd77, -1, 1'b0);
    chk("b2b_count", 32'(pulses.size()), 32'(np0 + 2));
    if (pulses.size() >= np0 + 2)
      chk("b2b_gap", 32'(pulses[np0 + 1] - pulses[np0]), 32'd34);

    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 1) ? DIV_OP : DIVU_OP;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = 32'hFFFFFFFF - $urandom_range(0, 15);
        default: b = $urandom_range(0, 3);
      endcase
      do_div(op, a, b, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle divider on the execute side of the ID/EX pipeline latch; consumes the latched ALU op and operands (`ex_aluop`, `ex_reg1`, `ex_reg2`).
- Executes DIV/DIVU by radix-2 restoring division, one quotient bit per cycle.
- Holds the pipeline via `stallreq` while busy.
- Presents the HI/LO result for one cycle to the EX-stage HI/LO write path.

Parameters:
- `DIV_OP`, 8'b00011010, aluop code for signed DIV.
- `DIVU_OP`, 8'b00011011, aluop code for unsigned DIVU.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `ex_aluop`  in  8  ALU op from ID/EX latch; held stable by the pipeline while `stallreq`=1.
- `ex_reg1`  in  32  dividend.
- `ex_reg2`  in  32  divisor.
- `annul`  in  1  flush; aborts any division in progress.
- `stallreq`  out  1  combinational pipeline stall request.
- `hi_o`  out  32  remainder.
- `lo_o`  out  32  quotient.
- `whilo_o`  out  1  HI/LO write enable, one-cycle pulse.

Behaviour:
- Reset: synchronous and active-high. `rst`=1 at a rising edge forces state IDLE and clears all internal registers. This applies mid-operation too, with no result produced. While in reset, `stallreq`=0, `whilo_o`=0, `hi_o`=0, `lo_o`=0.
- `is_div` = (`ex_aluop`==`DIV_OP`) or (`ex_aluop`==`DIVU_OP`).
- States: IDLE, DIVZERO, ON, END; 2-bit state register.
- IDLE:
  - If `is_div` && !`annul`:
    - Divisor==0: next state is DIVZERO.
    - Otherwise: latch operands. For DIV, take magnitudes (two's-complement negate of negative operands) and record `sign_q`=dividend[31]^divisor[31] and `sign_r`=dividend[31]. For DIVU, both signs are 0. Clear the 6-bit counter; next state is ON.
- DIVZERO: one cycle; result forced to quotient=0, remainder=0; next state is END.
- ON, each cycle:
  - Partial remainder (33 bits) is shifted left, taking the next dividend bit MSB-first.
  - Trial subtract the zero-extended divisor. If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments. After 32 steps (counter==31 at the edge), next state is END.
- END:
  - Apply sign correction: quotient negated if `sign_q`, remainder negated if `sign_r`.
  - `whilo_o`=1, `hi_o`=remainder, `lo_o`=quotient for exactly this cycle.
  - Next state is IDLE unconditionally.
- Outputs outside END: `whilo_o`=0, `hi_o`=0, `lo_o`=0.
- `stallreq` = `is_div` && (state!=END) && !`annul`; combinational. It is asserted in the same cycle the op first appears and drops in END, so the pipeline advances on the END edge.
- Latency, counted from cycle 0 (op first presented in IDLE):
  - Nonzero divisor: END at cycle 33 (1 start + 32 steps).
  - Divide by zero: END at cycle 2.
- Back-to-back divides: the new op appears in the cycle after END; the IDLE→start path handles it with no bubble beyond the normal latency.
- `annul`=1 in any state: next state is IDLE, no `whilo_o` pulse; `stallreq`=0 in that same cycle. If `annul` coincides with END, the result is suppressed (`whilo_o`=0).
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps), remainder 0. No exception is raised.
- Non-division ops: the block stays in IDLE with all outputs 0.

Optional Feature:
- Macro: `DIV_ZERO_TRAP_EN`.
- Defined: adds output port `div_zero_o` (1 bit, reset 0). It is 1 during the END cycle reached via DIVZERO and 0 otherwise; it is suppressed by `annul`. HI/LO behaviour is unchanged (still 0/0 with `whilo_o`=1).
- Undefined: the port and its logic are absent; divide by zero is silent.

Test Plan:
- DIVU, `ex_reg1`=100, `ex_reg2`=7, held for the stall → `stallreq`=1 for cycles 0..32; at cycle 33 `whilo_o`=1, `lo_o`=14, `hi_o`=2, `stallreq`=0.
- DIV, dividend 0xFFFFFFF9 (-7), divisor 2 → at cycle 33 `lo_o`=0xFFFFFFFD (-3), `hi_o`=0xFFFFFFFF (-1); DIV 7/-2 gives `lo_o`=0xFFFFFFFD, `hi_o`=1.
- DIV with divisor 0, dividend 0x12345678 → END at cycle 2: `whilo_o`=1, `hi_o`=0, `lo_o`=0; with `DIV_ZERO_TRAP_EN`, `div_zero_o`=1 in that cycle only.
- DIV 0x80000000 / 0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0 at cycle 33; no other output anomaly.
- DIVU 1000/10, then `annul`=1 at cycle 10 → `stallreq`=0 at cycle 10, state IDLE at cycle 11, no `whilo_o` pulse ever; a following DIVU 9/3 completes normally with `lo_o`=3, `hi_o`=0.
- `rst`=1 at cycle 20 of a DIVU → all outputs 0 next cycle, no `whilo_o`. Two DIVU ops presented back-to-back produce two `whilo_o` pulses exactly 34 cycles apart.
